// File: rtl/rgb_hue_sequencer_pkg.sv
// rgb_seq_pkg: phase encoding and per-phase channel sources for the hue wheel.
package rgb_seq_pkg;

    localparam int PHASE_COUNT = 6;

    typedef enum logic [2:0] {
        PH_G_UP,
        PH_R_DN,
        PH_B_UP,
        PH_G_DN,
        PH_R_UP,
        PH_B_DN
    } phase_t;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RISE,
        SRC_FALL,
        SRC_FULL
    } duty_src_t;

    typedef struct packed {
        duty_src_t r;
        duty_src_t g;
        duty_src_t b;
    } duty_src3_t;

    // Each phase holds one channel at full, one at zero and ramps the third
    function automatic duty_src3_t phase_duty(phase_t ph);
        case (ph)
            PH_G_UP: return '{r: SRC_FULL, g: SRC_RISE, b: SRC_ZERO};
            PH_R_DN: return '{r: SRC_FALL, g: SRC_FULL, b: SRC_ZERO};
            PH_B_UP: return '{r: SRC_ZERO, g: SRC_FULL, b: SRC_RISE};
            PH_G_DN: return '{r: SRC_ZERO, g: SRC_FALL, b: SRC_FULL};
            PH_R_UP: return '{r: SRC_RISE, g: SRC_ZERO, b: SRC_FULL};
            PH_B_DN: return '{r: SRC_FULL, g: SRC_ZERO, b: SRC_FALL};
            default: return '{r: SRC_ZERO, g: SRC_ZERO, b: SRC_ZERO};
        endcase
    endfunction

endpackage

// File: rtl/rgb_hue_sequencer_if.sv
// rgb_hue_sequencer_if: control inputs and LED/status outputs of the hue sequencer.
// Carries step_req only when RGB_SEQ_MANUAL_STEP_EN is defined.
interface rgb_hue_sequencer_if;
    logic       en;
`ifdef RGB_SEQ_MANUAL_STEP_EN
    logic       step_req;
`endif
    logic       RGB_R;
    logic       RGB_G;
    logic       RGB_B;
    logic [2:0] phase;
    logic       cycle_done;

`ifdef RGB_SEQ_MANUAL_STEP_EN
    modport master (output en, output step_req, input RGB_R, input RGB_G, input RGB_B,
                    input phase, input cycle_done);
    modport slave  (input en, input step_req, output RGB_R, output RGB_G, output RGB_B,
                    output phase, output cycle_done);
`else
    modport master (output en, input RGB_R, input RGB_G, input RGB_B,
                    input phase, input cycle_done);
    modport slave  (input en, output RGB_R, output RGB_G, output RGB_B,
                    output phase, output cycle_done);
`endif
endinterface

// File: rtl/rgb_hue_sequencer_pwm_gen.sv
// rgb_pwm_gen: shared free-running PWM counter with period-aligned shadow duties
// and registered, polarity-adjusted LED pins.
module rgb_pwm_gen #(
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [PWM_BITS-1:0] duty_r_i,
    input  logic [PWM_BITS-1:0] duty_g_i,
    input  logic [PWM_BITS-1:0] duty_b_i,
    output logic                pin_r_o,
    output logic                pin_g_o,
    output logic                pin_b_o
);

    localparam logic OFF = ACTIVE_LOW != 0;

    logic [PWM_BITS-1:0]      cnt_q, cnt_d;
    logic [2:0][PWM_BITS-1:0] sh_q, sh_d;
    logic [2:0]               pin_q, pin_d;

    // Shadows only reload at the end of a period so a duty change never splits one
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sh_d  = cnt_q == '1 ? {duty_b_i, duty_g_i, duty_r_i} : sh_q;
        pin_d = {3{OFF}};
        for (int i = 0; i < 3; i++) pin_d[i] = OFF ^ (en_i && cnt_q < sh_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
            pin_q <= {3{OFF}};
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
            pin_q <= pin_d;
        end
    end

    assign pin_r_o = pin_q[0];
    assign pin_g_o = pin_q[1];
    assign pin_b_o = pin_q[2];

endmodule

// File: rtl/rgb_hue_sequencer.sv
// rgb_hue_sequencer: prescaler, ramp and six-phase hue FSM feeding a shared RGB PWM.
// Define RGB_SEQ_MANUAL_STEP_EN to add a step_req input ORed with the prescaler strobe.
module rgb_hue_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP_CLKS  = 7812,
    parameter int ACTIVE_LOW = 1
) (
    input logic                clk,
    input logic                rst_n,
    rgb_hue_sequencer_if.slave bus
);

    localparam int                  PW  = $clog2(STEP_CLKS + 1);
    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] ramp_q, ramp_d;
    phase_t              phase_q, phase_d;
    logic                done_q, done_d;
    logic                tc, step, wrap;
    duty_src3_t          src;

    function automatic logic [PWM_BITS-1:0] src_val(duty_src_t s, logic [PWM_BITS-1:0] r);
        return s == SRC_ZERO ? '0 : s == SRC_RISE ? r : s == SRC_FALL ? MAX - r : MAX;
    endfunction

    always_comb begin
        tc      = bus.en && presc_q == PW'(STEP_CLKS - 1);
`ifdef RGB_SEQ_MANUAL_STEP_EN
        step    = tc || (bus.en && bus.step_req);
`else
        step    = tc;
`endif
        wrap    = step && ramp_q == MAX;
        presc_d = !bus.en ? presc_q : tc ? '0 : presc_q + 1'b1;
        ramp_d  = step ? ramp_q + 1'b1 : ramp_q;
        phase_d = !wrap ? phase_q
                : phase_q == phase_t'(3'(PHASE_COUNT - 1)) ? PH_G_UP
                : phase_t'(phase_q + 3'd1);
        done_d  = wrap && phase_q == phase_t'(3'(PHASE_COUNT - 1));
        src     = phase_duty(phase_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            ramp_q  <= '0;
            phase_q <= PH_G_UP;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ramp_q  <= ramp_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.cycle_done = done_q;

    rgb_pwm_gen #(
        .PWM_BITS  (PWM_BITS),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (bus.en),
        .duty_r_i(src_val(src.r, ramp_q)),
        .duty_g_i(src_val(src.g, ramp_q)),
        .duty_b_i(src_val(src.b, ramp_q)),
        .pin_r_o (bus.RGB_R),
        .pin_g_o (bus.RGB_G),
        .pin_b_o (bus.RGB_B)
    );

endmodule
